// File: rtl/acondicionador_entradas_if.sv
// Signal bundle between the raw elevator inputs and their conditioned versions.
// master drives the raw levels; slave is the conditioner itself.
interface acondicionador_entradas_if;
    logic [9:0] btn_raw;
    logic       piso_raw;
    logic       sens_raw;
    logic [9:0] botones;
    logic       cambio_piso;
    logic       sensor_puertas;

    modport master (
        output btn_raw, piso_raw, sens_raw,
        input  botones, cambio_piso, sensor_puertas
    );

    modport slave (
        input  btn_raw, piso_raw, sens_raw,
        output botones, cambio_piso, sensor_puertas
    );
endinterface

// File: rtl/acondicionador_entradas.sv
// Input conditioner: two-flop synchronizer plus counter debouncer on each of the
// 12 raw inputs, and a single-cycle pulse on each debounced floor-sensor rise.
module acondicionador_entradas #(
    parameter int unsigned DEB_CYC = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    acondicionador_entradas_if.slave  io
);
    localparam int unsigned N_CH     = 12;
    localparam int unsigned PISO_IDX = 10;
    localparam int unsigned SENS_IDX = 11;
    localparam logic [7:0]  CNT_MAX  = 8'(DEB_CYC - 1);

    logic [N_CH-1:0] raw_all;
    logic [N_CH-1:0] stable_all;
    logic            piso_rise;
    logic            pulse_reg;

    // Channel map: 0..9 buttons, 10 floor sensor, 11 door obstruction sensor.
    assign raw_all = {io.sens_raw, io.piso_raw, io.btn_raw};

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : gen_ch
            logic       s1_reg;
            logic       s2_reg;
            logic       stable_reg;
            logic [7:0] cnt_reg;
            logic       differs;
            logic       at_limit;

            assign differs  = (s2_reg != stable_reg);
            assign at_limit = (cnt_reg == CNT_MAX);

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg     <= 1'b0;
                    s2_reg     <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= 8'd0;
                end else begin
                    s1_reg <= raw_all[gi];
                    s2_reg <= s1_reg;
                    // Any return to the stable level before the limit throws away the count.
                    if (!differs) begin
                        cnt_reg <= 8'd0;
                    end else if (at_limit) begin
                        stable_reg <= s2_reg;
                        cnt_reg    <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            end

            assign stable_all[gi] = stable_reg;

            // The floor channel flags the edge on which its stable bit goes 0->1.
            if (gi == PISO_IDX) begin : gen_rise
                assign piso_rise = differs & at_limit & s2_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_reg <= 1'b0;
        end else begin
            pulse_reg <= piso_rise;
        end
    end

    assign io.botones        = stable_all[9:0];
    assign io.sensor_puertas = stable_all[SENS_IDX];
    assign io.cambio_piso    = pulse_reg;
endmodule

// File: tb/tb_acondicionador_entradas.sv
// Directed bench for the input conditioner with DEB_CYC = 8: latency, glitch,
// bounce, floor pulse, reset and simultaneous-update scenarios.
module tb_acondicionador_entradas;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   pulses;

    acondicionador_entradas_if io ();

    acondicionador_entradas #(.DEB_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word: {sensor_puertas, cambio_piso, botones[9:0]}
    function automatic logic [11:0] outs();
        return {io.sensor_puertas, io.cambio_piso, io.botones};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        io.btn_raw  = 10'h000;
        io.piso_raw = 1'b0;
        io.sens_raw = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pulses = 0;
        clear_inputs();
        do_reset();
        check("reset_state", 16'(outs()), 16'h000);

        // Latency on a single button, exact edge
        io.btn_raw = 10'h008;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("lat_wait", 16'(outs()), 16'h000);
        end
        tick();
        check("lat_edge10", 16'(outs()), 16'h008);
        io.btn_raw = 10'h000;
        for (int k = 1; k <= 10; k++) tick();
        check("lat_release", 16'(outs()), 16'h000);

        // Short obstruction glitch must vanish
        clear_inputs();
        do_reset();
        io.sens_raw = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("glitch_hi", 16'(outs()), 16'h000);
        end
        io.sens_raw = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("glitch_lo", 16'(outs()), 16'h000);
        end

        // 10-cycle obstruction pulse passes, then drops 10 edges after its fall
        io.sens_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("pulse10_rise", 16'(outs()), (k >= 10) ? 16'h800 : 16'h000);
        end
        io.sens_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("pulse10_fall", 16'(outs()), (k < 10) ? 16'h800 : 16'h000);
        end

        // Bouncing car button settles 10 edges after the last toggle
        clear_inputs();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            io.btn_raw[7] = (i % 2 == 0);
            tick();
            check("bounce_toggle", 16'(outs()), 16'h000);
        end
        io.btn_raw[7] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("bounce_hold", 16'(outs()), 16'h000);
        end
        tick();
        check("bounce_edge10", 16'(outs()), 16'h080);

        // Floor sensor: one pulse per debounced rise, none on the fall
        clear_inputs();
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            io.piso_raw = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (io.cambio_piso === 1'b1) pulses++;
                check("piso_high", 16'(outs()), (k == 10) ? 16'h400 : 16'h000);
            end
            io.piso_raw = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (io.cambio_piso === 1'b1) pulses++;
                check("piso_low", 16'(outs()), 16'h000);
            end
        end
        check("piso_pulse_count", 16'(pulses), 16'd2);

        // Reset mid-debounce discards the partial count
        clear_inputs();
        do_reset();
        io.btn_raw = 10'h001;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("midrst_pre", 16'(outs()), 16'h000);
        end
        reset = 1'b1;
        tick();
        check("midrst_edge6", 16'(outs()), 16'h000);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("midrst_wait", 16'(outs()), 16'h000);
        end
        tick();
        check("midrst_edge10", 16'(outs()), 16'h001);

        // All channels rising together, then held through a reset
        clear_inputs();
        do_reset();
        io.btn_raw  = 10'h3FF;
        io.piso_raw = 1'b1;
        io.sens_raw = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("simul_wait", 16'(outs()), 16'h000);
        end
        tick();
        check("simul_edge10", 16'(outs()), 16'hFFF);
        tick();
        check("simul_edge11", 16'(outs()), 16'hBFF);
        reset = 1'b1;
        tick();
        check("held_reset", 16'(outs()), 16'h000);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("held_wait", 16'(outs()), 16'h000);
        end
        tick();
        check("held_edge10", 16'(outs()), 16'hFFF);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("held_steady", 16'(outs()), 16'hBFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acondicionador_entradas.md
ACONDICIONADOR_ENTRADAS -- requirements
Module: acondicionador_entradas

Interface
REQ-001 Parameter DEB_CYC, default 8, cycles a synchronized input must differ from its stable value before the stable value changes; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 btn_raw  input  10  raw, asynchronous, bouncing call buttons, bit order identical to the elevator button encoding (bits 0..5 hall calls, bits 6..9 car calls for floors 1..4).
REQ-005 piso_raw  input  1  raw, asynchronous floor-passage sensor.
REQ-006 sens_raw  input  1  raw, asynchronous door-obstruction sensor.
REQ-007 botones  output  10  debounced, stable button levels; feeds the button registrar.
REQ-008 cambio_piso  output  1  one-cycle pulse per debounced floor-sensor rising edge; feeds the motion algorithm.
REQ-009 sensor_puertas  output  1  debounced, stable obstruction level; feeds door control.

Function
REQ-010 The block SHALL treat each of its 12 inputs as an independent channel; one channel's activity SHALL NOT affect another channel.
REQ-011 Each channel SHALL pass its input through two flip-flops (s1, s2) before use; s2 is the synchronized value.
REQ-012 Each channel SHALL hold a stable bit and an 8-bit counter cnt.
REQ-013 State IGUAL (s2 == stable): the counter SHALL load 0 on every edge.
REQ-014 State DISTINTO (s2 != stable) with cnt < DEB_CYC-1: the counter SHALL increment by 1 on each edge.
REQ-015 State DISTINTO with cnt == DEB_CYC-1: stable SHALL load s2 and the counter SHALL load 0 on that edge.
REQ-016 If s2 returns to stable before the update, the counter SHALL clear, so any glitch shorter than DEB_CYC synchronized cycles is fully rejected.
REQ-017 The counter SHALL never exceed DEB_CYC-1 and SHALL never wrap.
REQ-018 Latency: a raw level held constant SHALL appear on the stable output after rising edge DEB_CYC+2, counting as edge 1 the first edge at which s1 samples the new level.
REQ-019 botones[i] and sensor_puertas SHALL be the registered stable bits of their channels, with no combinational path from the raw inputs.
REQ-020 cambio_piso SHALL be registered and SHALL go high on the same edge at which the piso stable bit changes 0->1.
REQ-021 cambio_piso SHALL return low on the following edge.
REQ-022 A 1->0 change of the piso stable bit SHALL NOT produce a pulse.
REQ-023 The block SHALL produce at most one cambio_piso pulse per debounced rising edge, however long piso_raw stays high.
REQ-024 When several channels reach their update threshold on the same edge, all SHALL update on that edge.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL clear all s1, s2, stable bits, counters and the pulse register to 0.
REQ-026 Outputs SHALL therefore be botones=0, cambio_piso=0, sensor_puertas=0 in the cycle after any reset edge.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count.
REQ-028 An input held high through reset release SHALL reappear at edge DEB_CYC+2 after release, counting the first non-reset edge as edge 1.
REQ-029 If that input is piso_raw, the block SHALL emit exactly one cambio_piso pulse on reappearance.

Verification
REQ-030 Latency (DEB_CYC=8): btn_raw[3] 0->1 and held -> botones[3]=1 after edge 10; all other bits stay 0; the bench checks this edge exactly, not just "eventually".
REQ-031 Glitch rejection: sens_raw high for 5 cycles, then low -> sensor_puertas stays 0 throughout; a 10-cycle high pulse -> sensor_puertas goes 1 after edge 10 and 0 again 10 edges after the falling edge.
REQ-032 Bounce: btn_raw[7] toggles every cycle for 6 cycles, then holds 1 -> botones[7] rises exactly 10 edges after the last toggle, with no intermediate 1.
REQ-033 Floor pulse: piso_raw high for 30 cycles -> cambio_piso=1 for exactly one cycle, aligned with edge 10; falling edge -> no pulse; repeated twice -> exactly two pulses.
REQ-034 Reset mid-operation: btn_raw[0] high, reset pulsed at edge 6 -> botones[0] stays 0 and rises 10 edges after reset release.
REQ-035 Simultaneous: all 12 raw inputs rise on the same edge -> botones=10'h3FF, sensor_puertas=1 and a cambio_piso pulse, all after edge 10.
